// File: rtl/multicycle_control.sv
// Multicycle sequencing controller: fetch/decode/exec/mem/wb FSM that owns
// the IR and instret and drives ALU, memory, writeback and PC strobes.
// Optional jal support is enabled by defining MINIRISCV_JAL_EN.
// Ports: clk, rst (async, active-high); inst/imem_req/imem_ready fetch
// handshake; dmem_req/dmem_we/dmem_ready data handshake; zero ALU flag;
// alu_op/alu_src/alu_funct3/alu_funct7 ALU control; rs1/rs2/rd register
// addresses; reg_write/wb_sel writeback; pc_write/pc_sel PC update;
// instret retired count; trap sticky illegal-instruction flag.
module multicycle_control (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] inst,
  output logic        imem_req,
  input  logic        imem_ready,
  output logic        dmem_req,
  output logic        dmem_we,
  input  logic        dmem_ready,
  input  logic        zero,
  output logic [1:0]  alu_op,
  output logic        alu_src,
  output logic [2:0]  alu_funct3,
  output logic [6:0]  alu_funct7,
  output logic [4:0]  rs1,
  output logic [4:0]  rs2,
  output logic [4:0]  rd,
  output logic        reg_write,
  output logic [1:0]  wb_sel,
  output logic        pc_write,
  output logic [1:0]  pc_sel,
  output logic [31:0] instret,
  output logic        trap
);

`ifdef MINIRISCV_JAL_EN
  localparam bit JalEn = 1'b1;
`else
  localparam bit JalEn = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t      state, state_nx;
  logic [31:0] ir;

  logic [6:0] opc, f7;
  logic [2:0] f3;
  logic is_r, is_i, is_lw, is_sw, is_br, is_jal, legal;
  logic taken;

  assign opc = ir[6:0];
  assign f3  = ir[14:12];
  assign f7  = ir[31:25];

  always_comb begin
    is_r   = (opc == 7'b0110011) &&
             ((f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20)) ||
              ((f3 == 3'd6 || f3 == 3'd7) && f7 == 7'h00));
    is_i   = (opc == 7'b0010011) &&
             (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7);
    is_lw  = (opc == 7'b0000011) && (f3 == 3'd2);
    is_sw  = (opc == 7'b0100011) && (f3 == 3'd2);
    is_br  = (opc == 7'b1100011) && (f3 == 3'd0 || f3 == 3'd1);
    is_jal = JalEn && (opc == 7'b1101111);
    legal  = is_r | is_i | is_lw | is_sw | is_br | is_jal;
  end

  // beq (f3=0) takes on zero, bne (f3=1) on not-zero
  assign taken = f3[0] ? ~zero : zero;

  assign rs1        = ir[19:15];
  assign rs2        = ir[24:20];
  assign rd         = ir[11:7];
  assign alu_funct3 = f3;
  // only R-type forwards funct7 so addi immediates never pick subtract
  assign alu_funct7 = is_r ? f7 : 7'd0;
  assign trap       = (state == S_TRAP);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= S_FETCH;
      ir      <= '0;
      instret <= '0;
    end else begin
      state <= state_nx;
      if (state == S_FETCH && imem_ready)
        ir <= inst;
      if (pc_write)
        instret <= instret + 32'd1;
    end
  end

  always_comb begin
    state_nx  = state;
    imem_req  = 1'b0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    alu_op    = 2'b00;
    alu_src   = 1'b0;
    reg_write = 1'b0;
    wb_sel    = 2'b00;
    pc_write  = 1'b0;
    pc_sel    = 2'b00;

    if (state == S_EXEC || state == S_MEM || state == S_WB) begin
      unique case (1'b1)
        is_r:          alu_op = 2'b10;
        is_i:          begin alu_op = 2'b10; alu_src = 1'b1; end
        is_lw | is_sw: alu_src = 1'b1;
        is_br:         alu_op = 2'b01;
        default:       ;
      endcase
    end

    unique case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) state_nx = S_DECODE;
      end
      S_DECODE: begin
        if (!legal)      state_nx = S_TRAP;
        else if (is_jal) state_nx = S_WB;
        else             state_nx = S_EXEC;
      end
      S_EXEC: begin
        if (is_br) begin
          pc_write = 1'b1;
          pc_sel   = taken ? 2'b01 : 2'b00;
          state_nx = S_FETCH;
        end else if (is_lw || is_sw) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_sw;
        // sw retires in the ready cycle to keep its 4-cycle latency
        if (dmem_ready) begin
          if (is_sw) begin
            pc_write = 1'b1;
            state_nx = S_FETCH;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        pc_write  = 1'b1;
        wb_sel    = is_lw ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        pc_sel    = is_jal ? 2'b10 : 2'b00;
        state_nx  = S_FETCH;
      end
      S_TRAP:  ;
      default: state_nx = S_FETCH;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction phase
// sequences from the instruction class drive a cycle-by-cycle model.
module tb_multicycle_control;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] inst = '0;
  logic        imem_ready = 1'b0;
  logic        dmem_ready = 1'b0;
  logic        zero = 1'b0;
  logic        imem_req, dmem_req, dmem_we, alu_src;
  logic [1:0]  alu_op, wb_sel, pc_sel;
  logic [2:0]  alu_funct3;
  logic [6:0]  alu_funct7;
  logic [4:0]  rs1, rs2, rd;
  logic        reg_write, pc_write, trap;
  logic [31:0] instret;

  multicycle_control dut (
    .clk(clk), .rst(rst), .inst(inst),
    .imem_req(imem_req), .imem_ready(imem_ready),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ready(dmem_ready),
    .zero(zero), .alu_op(alu_op), .alu_src(alu_src),
    .alu_funct3(alu_funct3), .alu_funct7(alu_funct7),
    .rs1(rs1), .rs2(rs2), .rd(rd),
    .reg_write(reg_write), .wb_sel(wb_sel),
    .pc_write(pc_write), .pc_sel(pc_sel),
    .instret(instret), .trap(trap)
  );

  always #5 clk = ~clk;

  typedef enum int {C_R, C_I, C_LW, C_SW, C_BR, C_JAL, C_ILL} cls_t;
  typedef enum int {P_F, P_D, P_E, P_M, P_W, P_T} ph_t;

  typedef struct packed {
    logic       imr, dmr, we;
    logic [1:0] op;
    logic       src;
    logic [2:0] f3;
    logic [6:0] f7;
    logic [4:0] rs1, rs2, rd;
    logic       rw;
    logic [1:0] ws;
    logic       pw;
    logic [1:0] ps;
    logic       tr;
  } out_t;

  out_t act;
  always_comb act = {imem_req, dmem_req, dmem_we, alu_op, alu_src,
                     alu_funct3, alu_funct7, rs1, rs2, rd,
                     reg_write, wb_sel, pc_write, pc_sel, trap};

  out_t        exp_o;
  logic [31:0] exp_ret;
  bit          chk = 1'b0;
  logic [31:0] m_ir = '0;
  logic [31:0] m_ret = '0;
  int          tests = 0;
  int          fails = 0;

  function automatic cls_t classify(logic [31:0] w);
    logic [6:0] op;
    logic [2:0] f3;
    logic [6:0] f7;
    op = w[6:0];
    f3 = w[14:12];
    f7 = w[31:25];
    if (op == 7'h33 && f3 == 3'd0 && (f7 == 7'h00 || f7 == 7'h20))
      return C_R;
    if (op == 7'h33 && (f3 == 3'd6 || f3 == 3'd7) && f7 == 7'h00)
      return C_R;
    if (op == 7'h13 && (f3 == 3'd0 || f3 == 3'd6 || f3 == 3'd7))
      return C_I;
    if (op == 7'h03 && f3 == 3'd2) return C_LW;
    if (op == 7'h23 && f3 == 3'd2) return C_SW;
    if (op == 7'h63 && f3 < 3'd2)  return C_BR;
`ifdef MINIRISCV_JAL_EN
    if (op == 7'h6F) return C_JAL;
`endif
    return C_ILL;
  endfunction

  function automatic out_t expect_out(ph_t p, logic [31:0] ir,
                                      logic z, logic dr);
    out_t o;
    cls_t c;
    logic tk;
    c = classify(ir);
    o = '0;
    o.f3  = ir[14:12];
    o.f7  = (c == C_R) ? ir[31:25] : 7'd0;
    o.rs1 = ir[19:15];
    o.rs2 = ir[24:20];
    o.rd  = ir[11:7];
    if (p == P_E || p == P_M || p == P_W) begin
      if (c == C_R) o.op = 2'd2;
      if (c == C_I) begin o.op = 2'd2; o.src = 1'b1; end
      if (c == C_LW || c == C_SW) o.src = 1'b1;
      if (c == C_BR) o.op = 2'd1;
    end
    tk = (ir[14:12] == 3'd0) ? z : !z;
    case (p)
      P_F: o.imr = 1'b1;
      P_E: if (c == C_BR) begin
        o.pw = 1'b1;
        o.ps = tk ? 2'd1 : 2'd0;
      end
      P_M: begin
        o.dmr = 1'b1;
        o.we  = (c == C_SW);
        o.pw  = (c == C_SW) && dr;
      end
      P_W: begin
        o.rw = 1'b1;
        o.pw = 1'b1;
        o.ws = (c == C_LW) ? 2'd1 : ((c == C_JAL) ? 2'd2 : 2'd0);
        o.ps = (c == C_JAL) ? 2'd2 : 2'd0;
      end
      P_T: o.tr = 1'b1;
      default: ;
    endcase
    return o;
  endfunction

  task automatic check(string name, logic [63:0] a, logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, a, e, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk) begin
      check("outs", 64'(act), 64'(exp_o));
      check("instret", 64'(instret), 64'(exp_ret));
    end
  end

  // entered just after a rising edge; leaves one cycle later
  task automatic step(ph_t p, logic ir_rdy, logic [31:0] iw,
                      logic dr, logic z);
    inst       = iw;
    imem_ready = ir_rdy;
    dmem_ready = dr;
    zero       = z;
    exp_o      = expect_out(p, m_ir, z, dr);
    exp_ret    = m_ret;
    chk        = 1'b1;
    @(posedge clk);
    #1;
    if (p == P_F && ir_rdy) m_ir = iw;
    if (exp_o.pw) m_ret = m_ret + 32'd1;
  endtask

  task automatic do_reset();
    chk = 1'b0;
    #2 rst = 1'b1;
    #1;
    m_ir  = '0;
    m_ret = '0;
    check("reset_outs", 64'(act), 64'(expect_out(P_F, 32'd0, 1'b0, 1'b0)));
    check("reset_instret", 64'(instret), 64'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic run_instr(logic [31:0] w, int wi, int wd, logic z,
                           bit abort, output int ncyc);
    cls_t c;
    ph_t  seq[$];
    int   fi, mi;
    c = classify(w);
    for (int k = 0; k <= wi; k++) seq.push_back(P_F);
    seq.push_back(P_D);
    case (c)
      C_R, C_I: begin seq.push_back(P_E); seq.push_back(P_W); end
      C_LW, C_SW: begin
        seq.push_back(P_E);
        for (int k = 0; k <= wd; k++) seq.push_back(P_M);
        if (c == C_LW) seq.push_back(P_W);
      end
      C_BR:  seq.push_back(P_E);
      C_JAL: seq.push_back(P_W);
      default: for (int k = 0; k < 4; k++) seq.push_back(P_T);
    endcase
    ncyc = seq.size();
    fi = 0;
    mi = 0;
    foreach (seq[k]) begin
      ph_t         p;
      logic        rdy, dr, zz;
      logic [31:0] iw;
      p   = seq[k];
      iw  = $urandom;
      rdy = 1'($urandom_range(0, 1));
      dr  = 1'($urandom_range(0, 1));
      zz  = 1'($urandom_range(0, 1));
      if (p == P_F) begin
        rdy = (fi == wi);
        if (rdy) iw = w;
        fi++;
      end
      if (p == P_M) begin
        dr = (mi == wd) && !abort;
        mi++;
      end
      if (p == P_E) zz = z;
      step(p, rdy, iw, dr, zz);
      if (abort && p == P_M) begin
        check("abort_dmem_req", 64'(dmem_req), 64'd1);
        do_reset();
        return;
      end
    end
    if (c == C_ILL) begin
      check("trap_flag", 64'(trap), 64'd1);
      do_reset();
    end
  endtask

  function automatic logic [31:0] rand_word();
    logic [31:0] w;
    int          k, s;
    w = $urandom;
    k = $urandom_range(0, 9);
    s = $urandom_range(0, 2);
    case (k)
      0, 8: begin
        w[6:0]   = 7'h33;
        w[14:12] = (s == 0) ? 3'd0 : ((s == 1) ? 3'd6 : 3'd7);
        w[31:25] = (s == 0 && w[31]) ? 7'h20 : 7'h00;
      end
      1, 9: begin
        w[6:0]   = 7'h13;
        w[14:12] = (s == 0) ? 3'd0 : ((s == 1) ? 3'd6 : 3'd7);
      end
      2: begin w[6:0] = 7'h03; w[14:12] = 3'd2; end
      3: begin w[6:0] = 7'h23; w[14:12] = 3'd2; end
      4: begin w[6:0] = 7'h63; w[14:12] = {2'b00, w[12]}; end
      5: w[6:0] = 7'h6F;
      7: w[6:0] = 7'h33;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    run_instr(32'h002081B3, 0, 0, 1'b0, 1'b0, n);
    check("add_cycles", 64'(n), 64'd4);
    check("add_instret", 64'(instret), 64'd1);
    run_instr(32'h402081B3, 0, 0, 1'b0, 1'b0, n);
    check("sub_f7", 64'(expect_out(P_E, m_ir, 1'b0, 1'b0).f7), 64'h20);
    run_instr(32'hFFF00093, 1, 0, 1'b0, 1'b0, n);
    check("addi_f7", 64'(expect_out(P_E, m_ir, 1'b0, 1'b0).f7), 64'h00);
    run_instr(32'h00208463, 0, 0, 1'b1, 1'b0, n);
    check("beq_cycles", 64'(n), 64'd3);
    run_instr(32'h00208463, 0, 0, 1'b0, 1'b0, n);
    run_instr(32'h0040A283, 0, 2, 1'b0, 1'b0, n);
    check("lw_cycles", 64'(n), 64'd7);
    check("lw_rd", 64'(rd), 64'd5);
    check("instret_6", 64'(instret), 64'd6);
    run_instr(32'h0020A223, 0, 0, 1'b0, 1'b0, n);
    check("sw_cycles", 64'(n), 64'd4);
    run_instr(32'h00000000, 0, 0, 1'b0, 1'b0, n);
    run_instr(32'h0040A283, 0, 3, 1'b0, 1'b1, n);
    run_instr(32'h010000EF, 0, 0, 1'b0, 1'b0, n);
`ifdef MINIRISCV_JAL_EN
    check("jal_cycles", 64'(n), 64'd3);
    check("jal_instret", 64'(instret), 64'd1);
`endif

    for (int i = 0; i < 400; i++) begin
      logic [31:0] w;
      cls_t        c;
      bit          ab;
      w  = rand_word();
      c  = classify(w);
      ab = (c == C_LW || c == C_SW) && ($urandom_range(0, 15) == 0);
      run_instr(w, $urandom_range(0, 2), $urandom_range(0, 2),
                1'($urandom_range(0, 1)), ab, n);
    end

    chk = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
